transport_rx_deframer: RTL and testbench

//  Multi-channel receive deframer between network byte stream and session layer. Buffers bytes,

---
 rtl/transport_pkg.sv | 30 +++
 rtl/rx_byte_fifo.sv | 51 +++++
 rtl/transport_rx_deframer.sv | 167 ++++++++++++++++
 tb/tb_transport_rx_deframer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transport_pkg.sv
// transport_pkg: shared constants, header field positions and deframer state encoding
package transport_pkg;

  localparam logic [1:0] KIND_CTRL  = 2'b01;
  localparam logic [1:0] KIND_AUDIO = 2'b10;

  // Header layout: [7:6] kind, [5:4] reserved, [3:0] channel id (ids >= N_CHAN are rejected)
  localparam int HDR_KIND_MSB = 7;
  localparam int HDR_KIND_LSB = 6;
  localparam int HDR_CH_MSB   = 3;
  localparam int HDR_CH_LSB   = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_C_HI,
    S_C_LO,
    S_SEQ,
    S_A_HI,
    S_A_LO,
    S_EMIT,
    S_DRAIN
  } state_t;

  // Channel tag width; a single-channel build still carries a 1-bit tag
  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: first-word-fall-through byte FIFO reporting occupancy, empty and full
module rx_byte_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic [7:0]                 i_wr_data,
  input  logic                       i_rd_en,
  output logic [7:0]                 o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full is judged on the occupancy before this cycle's pop, so a write into a full FIFO is lost
  assign o_full    = r_count == (AW+1)'(DEPTH);
  assign o_empty   = r_count == '0;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Byte storage; left unreset so it can map onto a RAM
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/transport_rx_deframer.sv
// transport_rx_deframer: buffers network bytes and decodes fixed-size packets into channel-tagged 16-bit words
module transport_rx_deframer
  import transport_pkg::*;
#(
  parameter int PKT_BYTES  = 16,
  parameter int FIFO_DEPTH = 2048,
  parameter int N_CHAN     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rcv_valid,
  input  logic [7:0]                rcv_byte,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [1:0]                out_kind,
  output logic [chan_w(N_CHAN)-1:0] out_chan,
  output logic [7:0]                out_seq,
  output logic [15:0]               out_data,
  output logic                      overflow,
  output logic [CNT_W-1:0]          hdr_err_cnt,
  output logic [CNT_W-1:0]          seq_gap_cnt,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int CH_W    = chan_w(N_CHAN);
  localparam int FA_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int SAMPLES = (PKT_BYTES - 2) / 2;
  localparam int SM_W    = $clog2(SAMPLES + 1);
  localparam int DR_W    = $clog2(PKT_BYTES);

  state_t          r_state;
  state_t          w_next;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_hdr_ok;
  logic [7:0]      w_rd_byte;
  logic [FA_W-1:0] w_count;
  logic [1:0]      w_hdr_kind;
  logic [3:0]      w_hdr_ch;
  logic [DR_W-1:0] r_drain;
  logic [SM_W-1:0] r_samples;
  logic [7:0]      r_last_seq [N_CHAN];
  logic [N_CHAN-1:0] r_seen;

  rx_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (rcv_valid),
    .i_wr_data(rcv_byte),
    .i_rd_en  (w_pop),
    .o_rd_data(w_rd_byte),
    .o_count  (w_count),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  assign w_hdr_kind = w_rd_byte[HDR_KIND_MSB:HDR_KIND_LSB];
  assign w_hdr_ch   = w_rd_byte[HDR_CH_MSB:HDR_CH_LSB];
  assign w_hdr_ok   = (w_hdr_kind == KIND_CTRL || w_hdr_kind == KIND_AUDIO) && 32'(w_hdr_ch) < N_CHAN;
  assign out_valid  = r_state == S_EMIT;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // Next state and FIFO pop; a packet is only started once all of its bytes are buffered
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  w_next = (!w_empty && w_count >= FA_W'(PKT_BYTES)) ? S_HDR : S_IDLE;
      S_HDR: begin
        w_pop  = 1'b1;
        w_next = !w_hdr_ok ? S_DRAIN : (w_hdr_kind == KIND_CTRL) ? S_C_HI : S_SEQ;
      end
      S_C_HI: begin
        w_pop  = 1'b1;
        w_next = S_C_LO;
      end
      S_C_LO: begin
        w_pop  = 1'b1;
        w_next = S_EMIT;
      end
      S_SEQ: begin
        w_pop  = 1'b1;
        w_next = S_A_HI;
      end
      S_A_HI: begin
        w_pop  = 1'b1;
        w_next = S_A_LO;
      end
      S_A_LO: begin
        w_pop  = 1'b1;
        w_next = S_EMIT;
      end
      S_EMIT:  w_next = !out_ready ? S_EMIT : (out_kind == KIND_CTRL) ? S_DRAIN :
                        (r_samples == SM_W'(1)) ? S_IDLE : S_A_HI;
      S_DRAIN: begin
        w_pop  = r_drain != '0;
        w_next = (r_drain > DR_W'(1)) ? S_DRAIN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word assembly, per-channel sequence tracking, drain/sample counters and header/gap statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      out_kind    <= '0;
      out_chan    <= '0;
      out_seq     <= '0;
      out_data    <= '0;
      r_drain     <= '0;
      r_samples   <= '0;
      r_seen      <= '0;
      hdr_err_cnt <= '0;
      seq_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_hdr_ok) begin
            out_kind  <= w_hdr_kind;
            out_chan  <= w_hdr_ch[CH_W-1:0];
            out_seq   <= '0;
            r_samples <= SM_W'(SAMPLES);
          end else begin
            r_drain <= DR_W'(PKT_BYTES - 1);
            if (!(&hdr_err_cnt)) hdr_err_cnt <= hdr_err_cnt + 1'b1;
          end
        end
        S_C_HI, S_A_HI: out_data[15:8] <= w_rd_byte;
        S_C_LO, S_A_LO: out_data[7:0] <= w_rd_byte;
        S_SEQ: begin
          out_seq              <= w_rd_byte;
          r_last_seq[out_chan] <= w_rd_byte;
          r_seen[out_chan]     <= 1'b1;
          if (r_seen[out_chan] && w_rd_byte != r_last_seq[out_chan] + 8'd1 && !(&seq_gap_cnt))
            seq_gap_cnt <= seq_gap_cnt + 1'b1;
        end
        S_EMIT: begin
          if (out_ready && out_kind == KIND_CTRL) r_drain <= DR_W'(PKT_BYTES - 3);
          if (out_ready && out_kind != KIND_CTRL) r_samples <= r_samples - 1'b1;
        end
        S_DRAIN: if (r_drain != '0) r_drain <= r_drain - 1'b1;
        default: ;
      endcase
    end
  end

  // Overflow flag and dropped-byte count for bytes arriving while the FIFO is full
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (rcv_valid && w_full) begin
      overflow <= 1'b1;
      if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_transport_rx_deframer.sv
// tb_transport_rx_deframer: randomized and directed checking of the deframer against a packet-level model
module tb_transport_rx_deframer;

  localparam int PB  = 16;
  localparam int FD  = 2048;
  localparam int NC  = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;
  localparam int NS  = (PB - 2) / 2;
  localparam int WW  = 2 + CHW + 8 + 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            rcv_valid;
  logic [7:0]      rcv_byte;
  logic            out_ready;
  logic            out_valid;
  logic [1:0]      out_kind;
  logic [CHW-1:0]  out_chan;
  logic [7:0]      out_seq;
  logic [15:0]     out_data;
  logic            overflow;
  logic [CW-1:0]   hdr_err_cnt;
  logic [CW-1:0]   seq_gap_cnt;
  logic [CW-1:0]   drop_cnt;

  int              checks = 0;
  int              failures = 0;
  int              n_words = 0;
  int              base;
  logic [WW-1:0]   last_word;
  logic [WW-1:0]   exp_q [$];
  logic [7:0]      pkt [PB];
  int              m_hdr_err;
  int              m_gap;
  logic [15:0]     m_seen;
  logic [7:0]      m_last [16];
  logic            rnd_ready = 1'b0;
  logic            held = 1'b0;
  logic [WW:0]     prev_out;
  logic [1:0]      p_kind;
  logic [3:0]      p_ch;

  always #5 clk = ~clk;

  transport_rx_deframer #(
    .PKT_BYTES (PB),
    .FIFO_DEPTH(FD),
    .N_CHAN    (NC),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rcv_valid  (rcv_valid),
    .rcv_byte   (rcv_byte),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_kind   (out_kind),
    .out_chan   (out_chan),
    .out_seq    (out_seq),
    .out_data   (out_data),
    .overflow   (overflow),
    .hdr_err_cnt(hdr_err_cnt),
    .seq_gap_cnt(seq_gap_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Handshake monitor: every accepted word must be the next model word; stalled words must hold
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if ({out_valid, out_kind, out_chan, out_seq, out_data} !== prev_out) begin
          failures++;
          $display("FAIL hold: got %0h, expected %0h", {out_valid, out_kind, out_chan, out_seq, out_data}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        last_word = {out_kind, out_chan, out_seq, out_data};
        n_words++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word: got %0h, expected no word", last_word);
        end else if (last_word !== exp_q[0]) begin
          failures++;
          $display("FAIL word: got %0h, expected %0h", last_word, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      held = out_valid && !out_ready;
      prev_out = {out_valid, out_kind, out_chan, out_seq, out_data};
    end
  end

  // Random backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rcv_valid = 1'b1;
    rcv_byte  = b;
    tick();
    rcv_valid = 1'b0;
  endtask

  // Packet-level model: predicts words and statistics from the header rules, then drives the bytes
  task automatic send_pkt(input int gap_max);
    logic [1:0] k;
    logic [3:0] ch;
    k  = pkt[0][7:6];
    ch = pkt[0][3:0];
    if (!((k == 2'b01 || k == 2'b10) && ch < NC)) begin
      m_hdr_err++;
    end else if (k == 2'b01) begin
      exp_q.push_back({k, ch[CHW-1:0], 8'h00, pkt[1], pkt[2]});
    end else begin
      if (m_seen[ch] && pkt[1] != 8'(m_last[ch] + 8'd1)) m_gap++;
      m_seen[ch] = 1'b1;
      m_last[ch] = pkt[1];
      for (int i = 0; i < NS; i++) exp_q.push_back({k, ch[CHW-1:0], pkt[1], pkt[2+2*i], pkt[3+2*i]});
    end
    for (int i = 0; i < PB; i++) send_byte(pkt[i], gap_max == 0 ? 0 : int'($urandom_range(0, gap_max)));
  endtask

  task automatic set_ctrl(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
    pkt[0] = h;
    pkt[1] = a;
    pkt[2] = b;
    for (int i = 3; i < PB; i++) pkt[i] = 8'($urandom);
  endtask

  task automatic set_audio(input logic [7:0] h, input logic [7:0] s, input logic [15:0] first);
    logic [15:0] v;
    pkt[0] = h;
    pkt[1] = s;
    for (int i = 0; i < NS; i++) begin
      v = first + 16'(i);
      pkt[2+2*i] = v[15:8];
      pkt[3+2*i] = v[7:0];
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (PB + 6) tick();
  endtask

  task automatic do_reset(input string tag);
    rnd_ready = 1'b0;
    reset     = 1'b1;
    rcv_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
    m_hdr_err = 0;
    m_gap     = 0;
    m_seen    = '0;
    chk({tag, "_out"}, 64'({out_valid, out_kind, out_chan, out_seq, out_data}), 64'd0);
    chk({tag, "_stat"}, 64'({overflow, hdr_err_cnt, seq_gap_cnt, drop_cnt}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    out_ready = 1'b1;
    rcv_byte  = 8'h00;
    do_reset("reset");
    base = n_words;
    repeat (30) tick();
    chk("idle_no_words", 64'(n_words - base), 64'd0);

    set_ctrl(8'h41, 8'hAB, 8'hCD);
    base = n_words;
    send_pkt(0);
    wait_done();
    chk("ctrl_count", 64'(n_words - base), 64'd1);
    chk("ctrl_word", 64'(last_word), 64'({2'b01, 2'd1, 8'h00, 16'hABCD}));

    set_audio(8'h82, 8'h05, 16'h0001);
    base = n_words;
    send_pkt(0);
    wait_done();
    chk("audio_count", 64'(n_words - base), 64'd7);
    chk("audio_last", 64'(last_word), 64'({2'b10, 2'd2, 8'h05, 16'h0007}));

    do_reset("reset_gap");
    set_audio(8'h80, 8'h05, 16'h1111);
    send_pkt(0);
    set_audio(8'h80, 8'h07, 16'h2222);
    send_pkt(0);
    set_audio(8'h83, 8'hFF, 16'h3333);
    send_pkt(0);
    set_audio(8'h83, 8'h00, 16'h4444);
    send_pkt(0);
    wait_done();
    chk("gap_cnt", 64'(seq_gap_cnt), 64'd1);
    chk("gap_model", 64'(m_gap), 64'd1);

    do_reset("reset_hdr");
    set_ctrl(8'hC0, 8'h55, 8'h66);
    send_pkt(0);
    set_ctrl(8'h42, 8'h12, 8'h34);
    base = n_words;
    send_pkt(0);
    set_ctrl(8'h87, 8'h77, 8'h88);
    send_pkt(0);
    wait_done();
    chk("hdr_err_cnt", 64'(hdr_err_cnt), 64'd2);
    chk("hdr_err_model", 64'(m_hdr_err), 64'd2);
    chk("hdr_ok_count", 64'(n_words - base), 64'd1);
    chk("hdr_ok_word", 64'(last_word), 64'({2'b01, 2'd2, 8'h00, 16'h1234}));

    do_reset("reset_stall");
    set_audio(8'h81, 8'h10, 16'h1000);
    base = n_words;
    send_pkt(0);
    for (int n = 0; n < 300 && n_words < base + 3; n++) tick();
    chk("stall_reach", 64'(n_words - base), 64'd3);
    out_ready = 1'b0;
    repeat (100) tick();
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data", 64'(out_data), 64'h1003);
    out_ready = 1'b1;
    wait_done();
    chk("stall_count", 64'(n_words - base), 64'd7);

    do_reset("reset_rand");
    rnd_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      p_kind = ($urandom_range(0, 9) < 4) ? 2'b10 : ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom);
      p_ch   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, NC - 1));
      pkt[0] = {p_kind, 2'($urandom), p_ch};
      for (int i = 1; i < PB; i++) pkt[i] = 8'($urandom);
      if (p_kind == 2'b10 && $urandom_range(0, 2) != 0) pkt[1] = m_last[p_ch] + 8'd1;
      send_pkt(2);
    end
    wait_done();
    rnd_ready = 1'b0;
    #3;
    out_ready = 1'b1;
    chk("rand_hdr_err", 64'(hdr_err_cnt), 64'(m_hdr_err));
    chk("rand_seq_gap", 64'(seq_gap_cnt), 64'(m_gap));
    chk("rand_no_drop", 64'({overflow, drop_cnt}), 64'd0);

    do_reset("reset_ovf");
    out_ready = 1'b0;
    set_ctrl(8'h41, 8'hAB, 8'hCD);
    for (int i = 0; i < PB; i++) send_byte(pkt[i], 0);
    for (int i = 0; i < FD + 6 - PB; i++) send_byte(8'($urandom), 0);
    repeat (2) tick();
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_stalled_word", 64'({out_valid, out_data}), 64'({1'b1, 16'hABCD}));
    do_reset("reset_mid");
    out_ready = 1'b1;
    base = n_words;
    repeat (40) tick();
    chk("post_reset_words", 64'(n_words - base), 64'd0);
    chk("post_reset_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
